// File: rtl/pwm_feedback_decoder.sv
// Decodes the fiber-returned left/right PWM pulse trains of one H-bridge cell:
// per-leg high width and period, narrow-pulse and loss-of-switching detection.

module pwm_feedback_leg #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LIM_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             faultClear,
    input  logic [LIM_W-1:0] limit,
    input  logic [15:0]      minWidth,
    input  logic             pwmFb,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             narrowFault,
    output logic             timeoutFault,
    output logic             stuckLevel
);

    localparam int unsigned CMP_W = (CNT_W > LIM_W) ? CNT_W : LIM_W;
    localparam int unsigned MIN_W = (CNT_W > 16) ? CNT_W : 16;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} legState_t;

    legState_t        state;
    logic             s1, s2, s3;
    logic             rise_c, fall_c;
    logic             timeoutHit_c, narrowHit_c;
    logic [CNT_W-1:0] perCnt, hiCnt, hiLat;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Two-flop synchroniser plus history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwmFb;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        rise_c       = s2 & ~s3;
        fall_c       = ~s2 & s3;
        timeoutHit_c = enable && (state != IDLE) && (limit != '0)
                       && (CMP_W'(perCnt) >= CMP_W'(limit));
        narrowHit_c  = enable && (state == HIGH) && !timeoutHit_c && fall_c
                       && (minWidth != '0) && (MIN_W'(hiCnt) < MIN_W'(minWidth));
    end

    // Measurement FSM; a timeout abandons the cycle without reporting it
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            perCnt <= '0;
            hiCnt  <= '0;
            hiLat  <= '0;
            width  <= '0;
            period <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable || timeoutHit_c) begin
                state  <= IDLE;
                perCnt <= '0;
                hiCnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise_c) begin
                            perCnt <= CNT_W'(1);
                            hiCnt  <= CNT_W'(1);
                            state  <= HIGH;
                        end
                    end
                    HIGH: begin
                        perCnt <= satInc(perCnt);
                        if (fall_c) begin
                            hiLat <= hiCnt;
                            state <= LOW;
                        end else begin
                            hiCnt <= satInc(hiCnt);
                        end
                    end
                    LOW: begin
                        if (rise_c) begin
                            period <= perCnt;
                            width  <= hiLat;
                            valid  <= 1'b1;
                            perCnt <= CNT_W'(1);
                            hiCnt  <= CNT_W'(1);
                            state  <= HIGH;
                        end else begin
                            perCnt <= satInc(perCnt);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Sticky faults: a new set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            narrowFault  <= 1'b0;
            timeoutFault <= 1'b0;
            stuckLevel   <= 1'b0;
        end else begin
            if (narrowHit_c) begin
                narrowFault <= 1'b1;
            end else if (faultClear) begin
                narrowFault <= 1'b0;
            end
            if (timeoutHit_c) begin
                timeoutFault <= 1'b1;
                stuckLevel   <= s2;
            end else if (faultClear) begin
                timeoutFault <= 1'b0;
                stuckLevel   <= 1'b0;
            end
        end
    end

endmodule

module pwm_feedback_decoder #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned TIMEOUT_MULT = 4
) (
    input  logic             clk_20M,
    input  logic             reset,
    input  logic             enable,
    input  logic [15:0]      Frequency,
    input  logic [15:0]      PulWidth_Min,
    input  logic             fault_clear,
    input  logic             PWM_fbLeft,
    input  logic             PWM_fbRight,
    output logic [CNT_W-1:0] WidthLeft,
    output logic [CNT_W-1:0] PeriodLeft,
    output logic             ValidLeft,
    output logic [CNT_W-1:0] WidthRight,
    output logic [CNT_W-1:0] PeriodRight,
    output logic             ValidRight,
    output logic [3:0]       Fault,
    output logic [1:0]       StuckLevel
);

    localparam int unsigned LIM_W = 18;

    logic [LIM_W-1:0] limit;
    logic             narrowLeft, timeoutLeft, stuckLeft;
    logic             narrowRight, timeoutRight, stuckRight;

    // Loss-of-switching limit, wide enough that the multiply never truncates
    assign limit = LIM_W'(TIMEOUT_MULT) * LIM_W'(Frequency);

    pwm_feedback_leg #(.CNT_W(CNT_W), .LIM_W(LIM_W)) legLeft (
        .clk          (clk_20M),
        .reset        (reset),
        .enable       (enable),
        .faultClear   (fault_clear),
        .limit        (limit),
        .minWidth     (PulWidth_Min),
        .pwmFb        (PWM_fbLeft),
        .width        (WidthLeft),
        .period       (PeriodLeft),
        .valid        (ValidLeft),
        .narrowFault  (narrowLeft),
        .timeoutFault (timeoutLeft),
        .stuckLevel   (stuckLeft)
    );

    pwm_feedback_leg #(.CNT_W(CNT_W), .LIM_W(LIM_W)) legRight (
        .clk          (clk_20M),
        .reset        (reset),
        .enable       (enable),
        .faultClear   (fault_clear),
        .limit        (limit),
        .minWidth     (PulWidth_Min),
        .pwmFb        (PWM_fbRight),
        .width        (WidthRight),
        .period       (PeriodRight),
        .valid        (ValidRight),
        .narrowFault  (narrowRight),
        .timeoutFault (timeoutRight),
        .stuckLevel   (stuckRight)
    );

    assign Fault      = {timeoutRight, narrowRight, timeoutLeft, narrowLeft};
    assign StuckLevel = {stuckRight, stuckLeft};

endmodule

// File: tb/tb_pwm_feedback_decoder.sv
// Directed bench for pwm_feedback_decoder: inputs change on the falling edge,
// outputs are checked on the following falling edge.

module tb_pwm_feedback_decoder;

    logic        clk_20M = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] Frequency = 16'd0;
    logic [15:0] PulWidth_Min = 16'd0;
    logic        fault_clear = 1'b0;
    logic        PWM_fbLeft = 1'b0;
    logic        PWM_fbRight = 1'b0;
    logic [15:0] WidthLeft, PeriodLeft, WidthRight, PeriodRight;
    logic        ValidLeft, ValidRight;
    logic [3:0]  Fault;
    logic [1:0]  StuckLevel;

    int total = 0;
    int bad = 0;

    pwm_feedback_decoder #(.CNT_W(16), .TIMEOUT_MULT(4)) dut (
        .clk_20M      (clk_20M),
        .reset        (reset),
        .enable       (enable),
        .Frequency    (Frequency),
        .PulWidth_Min (PulWidth_Min),
        .fault_clear  (fault_clear),
        .PWM_fbLeft   (PWM_fbLeft),
        .PWM_fbRight  (PWM_fbRight),
        .WidthLeft    (WidthLeft),
        .PeriodLeft   (PeriodLeft),
        .ValidLeft    (ValidLeft),
        .WidthRight   (WidthRight),
        .PeriodRight  (PeriodRight),
        .ValidRight   (ValidRight),
        .Fault        (Fault),
        .StuckLevel   (StuckLevel)
    );

    always #25 clk_20M = ~clk_20M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic l, input logic r);
        PWM_fbLeft  = l;
        PWM_fbRight = r;
        @(negedge clk_20M);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_wl"}, 32'(WidthLeft), 32'd0);
        chk({tag, "_pl"}, 32'(PeriodLeft), 32'd0);
        chk({tag, "_vl"}, 32'(ValidLeft), 32'd0);
        chk({tag, "_wr"}, 32'(WidthRight), 32'd0);
        chk({tag, "_pr"}, 32'(PeriodRight), 32'd0);
        chk({tag, "_vr"}, 32'(ValidRight), 32'd0);
        chk({tag, "_fault"}, 32'(Fault), 32'd0);
        chk({tag, "_stuck"}, 32'(StuckLevel), 32'd0);
    endtask

    initial begin
        int cntL, cntR, firstL, lastL, lastR, cntB;
        logic l, r;

        // Reset state
        enable = 1'b1;
        doReset();
        chkZero("reset");

        // Periodic 3 high / 5 low on left
        Frequency = 16'd100; PulWidth_Min = 16'd2;
        cntL = 0; cntR = 0; firstL = -1;
        for (int t = 0; t < 40; t++) begin
            step(1'((t % 8) < 3), 1'b0);
            if (ValidLeft) begin
                cntL++;
                if (firstL < 0) firstL = t;
                chk("train_w", 32'(WidthLeft), 32'd3);
                chk("train_p", 32'(PeriodLeft), 32'd8);
            end
            if (ValidRight) cntR++;
        end
        chk("train_cnt", 32'(cntL), 32'd4);
        chk("train_first", 32'(firstL), 32'd10);
        chk("train_rcnt", 32'(cntR), 32'd0);
        chk("train_fault", 32'(Fault), 32'd0);

        // Carrier-realistic, both legs, right shifted by 500
        Frequency = 16'd1000; PulWidth_Min = 16'd2;
        doReset();
        cntL = 0; cntR = 0; lastL = 0; lastR = 0;
        for (int t = 0; t < 6600; t++) begin
            l = 1'((t % 2000) < 700);
            r = 1'((t >= 500) && (((t - 500) % 2000) < 1300));
            step(l, r);
            if (ValidLeft) begin
                cntL++; lastL = t;
                chk("car_wl", 32'(WidthLeft), 32'd700);
                chk("car_pl", 32'(PeriodLeft), 32'd2000);
            end
            if (ValidRight) begin
                cntR++; lastR = t;
                chk("car_wr", 32'(WidthRight), 32'd1300);
                chk("car_pr", 32'(PeriodRight), 32'd2000);
            end
        end
        chk("car_cntl", 32'(cntL), 32'd3);
        chk("car_cntr", 32'(cntR), 32'd3);
        chk("car_skew", 32'(lastR - lastL), 32'd500);
        chk("car_fault", 32'(Fault), 32'd0);

        // Narrow 6-count pulse on right, then legal 20-count pulses
        Frequency = 16'd0; PulWidth_Min = 16'd10;
        doReset();
        cntR = 0;
        for (int t = 0; t < 86; t++) begin
            r = 1'((t < 6) || (t >= 20 && t < 40) || (t >= 60 && t < 80));
            step(1'b0, r);
            if (t == 7) chk("nar_pre", 32'(Fault), 32'd0);
            if (t == 8) chk("nar_set", 32'(Fault), 32'h4);
            if (ValidRight) begin
                if (cntR == 0) begin
                    chk("nar_w1", 32'(WidthRight), 32'd6);
                    chk("nar_p1", 32'(PeriodRight), 32'd20);
                end else begin
                    chk("nar_w2", 32'(WidthRight), 32'd20);
                    chk("nar_p2", 32'(PeriodRight), 32'd40);
                end
                cntR++;
            end
        end
        chk("nar_cnt", 32'(cntR), 32'd2);
        chk("nar_sticky", 32'(Fault), 32'h4);
        fault_clear = 1'b1;
        step(1'b0, 1'b0);
        fault_clear = 1'b0;
        chk("nar_clear", 32'(Fault), 32'd0);

        // Stuck high on left: limit 4*50 = 200
        Frequency = 16'd50; PulWidth_Min = 16'd0;
        doReset();
        cntL = 0; firstL = -1;
        for (int t = 0; t < 231; t++) begin
            l = 1'((t < 210) || (t >= 215 && t < 218) || (t >= 223));
            step(l, 1'b0);
            if (t == 201) chk("stk_pre", 32'(Fault), 32'd0);
            if (t == 202) begin
                chk("stk_fault", 32'(Fault), 32'h2);
                chk("stk_level", 32'(StuckLevel), 32'h1);
            end
            if (ValidLeft) begin
                cntL++;
                if (firstL < 0) firstL = t;
            end
        end
        chk("stk_vcnt", 32'(cntL), 32'd1);
        chk("stk_vat", 32'(firstL), 32'd225);
        chk("stk_w", 32'(WidthLeft), 32'd3);
        chk("stk_p", 32'(PeriodLeft), 32'd8);
        chk("stk_hold", 32'(Fault), 32'h2);
        fault_clear = 1'b1;
        step(1'b1, 1'b0);
        fault_clear = 1'b0;
        chk("stk_clr_f", 32'(Fault), 32'd0);
        chk("stk_clr_s", 32'(StuckLevel), 32'd0);

        // Clear and narrow set in the same cycle: set wins
        Frequency = 16'd0; PulWidth_Min = 16'd10;
        doReset();
        for (int t = 0; t < 10; t++) begin
            fault_clear = (t == 6) || (t == 7);
            step(1'(t < 4), 1'b0);
            if (t == 5) chk("col_pre", 32'(Fault), 32'd0);
            if (t == 6) chk("col_set", 32'(Fault), 32'h1);
            if (t == 7) chk("col_clr", 32'(Fault), 32'd0);
        end
        fault_clear = 1'b0;

        // enable dropped mid-HIGH, then re-raised
        Frequency = 16'd0; PulWidth_Min = 16'd0;
        doReset();
        cntL = 0; cntB = 0;
        for (int t = 0; t < 61; t++) begin
            if (t < 24)      l = 1'((t % 8) < 3);
            else if (t < 35) l = 1'b1;
            else if (t < 41) l = 1'b0;
            else if (t < 45) l = 1'b1;
            else if (t < 51) l = 1'b0;
            else if (t < 55) l = 1'b1;
            else             l = 1'b0;
            enable = !(t >= 30 && t <= 32);
            step(l, 1'b0);
            if (t == 32) begin
                chk("en_valid", 32'(ValidLeft), 32'd0);
                chk("en_hold_w", 32'(WidthLeft), 32'd3);
                chk("en_hold_p", 32'(PeriodLeft), 32'd8);
            end
            if (t == 48) begin
                chk("en_first_w", 32'(WidthLeft), 32'd3);
                chk("en_first_p", 32'(PeriodLeft), 32'd8);
            end
            if (ValidLeft) begin
                if (t < 33) cntL++;
                else begin
                    cntB++;
                    chk("en_w", 32'(WidthLeft), 32'd4);
                    chk("en_p", 32'(PeriodLeft), 32'd10);
                end
            end
        end
        chk("en_cnt_a", 32'(cntL), 32'd3);
        chk("en_cnt_b", 32'(cntB), 32'd1);

        // Synchronous reset in the middle of a high pulse
        repeat (6) step(1'b1, 1'b0);
        chk("rst_pre_w", 32'(WidthLeft), 32'd4);
        reset = 1'b1;
        step(1'b1, 1'b0);
        chkZero("rst_mid");
        reset = 1'b0;
        repeat (4) step(1'b1, 1'b0);
        chk("rst_after_v", 32'(ValidLeft), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_feedback_decoder.md
Name: pwm_feedback_decoder

Overview:
- Receive side of the CSPWM gate-drive path: decodes the left/right PWM pulse trains returned over the module fiber loopback for one H-bridge cell.
- Measures the high width and rising-to-rising period of each leg in clk_20M counts.
- Flags pulses narrower than the programmed minimum and legs that stop switching, so the controller can compare commanded and delivered switching.
- One instance per cell (A/B/C), placed beside CSPWM, sharing the same Frequency and PulWidth_Min settings.

Parameters:
- CNT_W, 16, width of the width/period counters and outputs.
- TIMEOUT_MULT, 4, loss-of-switching timeout expressed as a multiple of Frequency.

Ports:
- clk_20M  input  1  sole clock, 20 MHz.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = decode; 0 = legs forced to IDLE.
- Frequency  input  16  carrier half-period in clk_20M counts, same value CSPWM uses.
- PulWidth_Min  input  16  minimum legal high width in counts; 0 disables the narrow check.
- fault_clear  input  1  single-cycle pulse that clears the sticky fault bits.
- PWM_fbLeft  input  1  asynchronous returned left-leg pulse.
- PWM_fbRight  input  1  asynchronous returned right-leg pulse.
- WidthLeft  output  CNT_W  last complete high width, left leg.
- PeriodLeft  output  CNT_W  last complete period, left leg.
- ValidLeft  output  1  one-cycle strobe when WidthLeft/PeriodLeft update.
- WidthRight  output  CNT_W  as WidthLeft, right leg.
- PeriodRight  output  CNT_W  as PeriodLeft, right leg.
- ValidRight  output  1  as ValidLeft, right leg.
- Fault  output  4  sticky bits {right_timeout, right_narrow, left_timeout, left_narrow}.
- StuckLevel  output  2  {right, left}: synchronised level latched when that leg's timeout fired.

Behaviour:
- Reset: all outputs 0; counters 0; synchroniser flops 0; both legs in IDLE.
- Input path (per leg): 2-flop synchroniser s1→s2, plus history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Pin-to-edge-detect latency is 2 clocks.
- Leg FSM (identical for left and right). States: IDLE, HIGH, LOW.
  - IDLE: counters held at 0. On rise: per_cnt←1, hi_cnt←1, go to HIGH. The first rise after IDLE does not assert Valid.
  - HIGH: per_cnt and hi_cnt increment each cycle, saturating at 2^CNT_W−1. On fall: hi_lat←hi_cnt, go to LOW.
  - LOW: per_cnt increments (saturating). On rise: Period←per_cnt, Width←hi_lat, Valid=1 for that cycle, per_cnt←1, hi_cnt←1, go to HIGH.
  - Example: a pulse train with 3 cycles high and 5 cycles low gives Width=3, Period=8.
- Narrow check: on fall, if PulWidth_Min≠0 and hi_cnt < PulWidth_Min, set that leg's narrow bit.
  - The measurement is still reported at the next rise.
- Timeout:
  - Limit = TIMEOUT_MULT × Frequency, computed unsigned at 18 bits with no truncation.
  - In HIGH or LOW, if per_cnt ≥ limit: set that leg's timeout bit, StuckLevel[leg]←s2, go to IDLE. No Valid is asserted.
  - Frequency=0 disables the timeout.
- Fault bits are sticky and cleared only by fault_clear.
  - If a set and fault_clear occur in the same cycle, the set wins.
  - StuckLevel is cleared by fault_clear.
- enable=0: both FSMs go to IDLE and counters clear the next cycle. Width/Period/Fault hold; Valid=0. The synchroniser keeps running.
- Width/Period hold their last value between Valid strobes.
- The legs are fully independent: simultaneous edges on both legs are each processed in the same cycle, with no interaction.
- Reset asserted mid-pulse: applied on the next clock edge; no partial measurement is reported.

Test Plan:
- Periodic train: left leg 3 high / 5 low, Frequency=100, PulWidth_Min=2. After the first rise, every rise gives ValidLeft with WidthLeft=3, PeriodLeft=8; Fault=0.
- Carrier-realistic: both legs with period 2000 counts, widths 700 (left) and 1300 (right), right phase-shifted 500. Expect Period=2000 on both legs; Width 700/1300; Valid strobes 500 cycles apart.
- Narrow pulse: PulWidth_Min=10, a single 6-count pulse on the right leg. Fault[2] sets; Fault[2] stays set after further 20-count pulses; fault_clear zeros it.
- Stuck high: Frequency=50 (limit 200). Left rises and stays high. Fault[1]=1 and StuckLevel[0]=1 exactly when per_cnt reaches 200; the leg is in IDLE; the next rise produces no Valid; the following rise produces Valid.
- Clear vs set collision: fault_clear asserted in the same cycle a narrow fall is detected. The bit ends set. fault_clear alone on the next cycle clears it.
- Mid-operation control: enable dropped during HIGH, then re-raised. No Valid on the first rise afterwards; prior Width/Period held. Synchronous reset mid-pulse zeros all outputs on the next clock.
